// File: rtl/sar_sequencer.sv
// Purpose : SAR conversion controller that sequences sampling, one bit trial per cycle and result hand-off.
// Latency : start edge to data_valid high is SAMPLE_CYCLES+N_bits cycles; one result per SAMPLE_CYCLES+N_bits+1 cycles when streaming.
// Backpr. : a finished result waits in DONE with data_out stable until data_ready; start is ignored until then.
//
// Ports:
//   clk                 conversion clock, rising edge active
//   rst                 asynchronous active-low reset
//   start               conversion request, sampled in IDLE or on the DONE transfer edge
//   comparator_out      1 = Vin >= Vdac for the current trial, sampled at the end of each trial
//   data_ready          back end accepts data_out while data_valid is high
//   sample              sample switch control, high during SAMPLE
//   shift_register_out  one-hot phase pointer: bit N_bits = sample phase, bit k = trial of bit k
//   dac_code            trial code driven to the CDAC
//   data_out            last completed conversion result
//   data_valid          data_out holds an unconsumed result
//   busy                high in SAMPLE, CONVERT and DONE
module sar_sequencer #(
  parameter int N_bits        = 4,
  parameter int SAMPLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              comparator_out,
  input  logic              data_ready,
  output logic              sample,
  output logic [N_bits:0]   shift_register_out,
  output logic [N_bits-1:0] dac_code,
  output logic [N_bits-1:0] data_out,
  output logic              data_valid,
  output logic              busy
);

  localparam int K_W = (N_bits > 1) ? $clog2(N_bits) : 1;
  localparam int C_W = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAMPLE  = 2'd1,
    CONVERT = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Control state
  state_t            state, state_nxt;
  logic [C_W-1:0]    cnt, cnt_nxt;
  logic [K_W-1:0]    k_idx, k_nxt;
  logic [N_bits-1:0] result, result_nxt;

  // Next values of the registered outputs
  logic              sample_nxt;
  logic [N_bits:0]   sro_nxt;
  logic [N_bits-1:0] dac_nxt;
  logic [N_bits-1:0] data_out_nxt;
  logic              data_valid_nxt;
  logic              busy_nxt;
  logic [N_bits-1:0] trial_bit;

  // State register and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state              <= IDLE;
      cnt                <= '0;
      k_idx              <= '0;
      result             <= '0;
      sample             <= 1'b0;
      shift_register_out <= '0;
      dac_code           <= '0;
      data_out           <= '0;
      data_valid         <= 1'b0;
      busy               <= 1'b0;
    end else begin
      state              <= state_nxt;
      cnt                <= cnt_nxt;
      k_idx              <= k_nxt;
      result             <= result_nxt;
      sample             <= sample_nxt;
      shift_register_out <= sro_nxt;
      dac_code           <= dac_nxt;
      data_out           <= data_out_nxt;
      data_valid         <= data_valid_nxt;
      busy               <= busy_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    k_nxt          = k_idx;
    result_nxt     = result;
    data_out_nxt   = data_out;
    data_valid_nxt = data_valid;

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SAMPLE;
          cnt_nxt   = '0;
        end
      end

      SAMPLE: begin
        if (cnt == C_W'(SAMPLE_CYCLES - 1)) begin
          state_nxt  = CONVERT;
          k_nxt      = K_W'(N_bits - 1);
          result_nxt = '0;
        end else begin
          cnt_nxt = cnt + C_W'(1);
        end
      end

      CONVERT: begin
        // The comparator decision for the trial just closing fixes bit k.
        result_nxt[k_idx] = comparator_out;
        if (k_idx == '0) begin
          state_nxt      = DONE;
          data_out_nxt   = result_nxt;
          data_valid_nxt = 1'b1;
        end else begin
          k_nxt = k_idx - K_W'(1);
        end
      end

      DONE: begin
        if (data_valid && data_ready) begin
          data_valid_nxt = 1'b0;
          if (start) begin
            state_nxt = SAMPLE;
            cnt_nxt   = '0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Output values for the cycle being entered, derived from next state only,
  // so every output leaves a flop and no input reaches an output directly.
  always_comb begin
    sample_nxt = 1'b0;
    sro_nxt    = '0;
    dac_nxt    = '0;
    busy_nxt   = 1'b0;
    trial_bit  = '0;
    trial_bit[k_nxt] = 1'b1;

    case (state_nxt)
      SAMPLE: begin
        sample_nxt      = 1'b1;
        sro_nxt[N_bits] = 1'b1;
        busy_nxt        = 1'b1;
      end

      CONVERT: begin
        sro_nxt  = {1'b0, trial_bit};
        // Bits at and below k are still zero in result, so OR-ing in the
        // trial bit yields "decided bits above k, 1 at k, zeros below".
        dac_nxt  = result_nxt | trial_bit;
        busy_nxt = 1'b1;
      end

      DONE: begin
        dac_nxt  = result_nxt;
        busy_nxt = 1'b1;
      end

      default: begin
        sample_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_sar_sequencer.sv
// Purpose : self-checking bench for sar_sequencer at default parameters.
// Latency : n/a (bench).
// Backpr. : drives data_ready low for chosen hold periods to exercise DONE stalls.
module tb_sar_sequencer;

  localparam int N  = 4;
  localparam int SC = 2;

  logic         clk;
  logic         rst;
  logic         start;
  logic         comparator_out;
  logic         data_ready;
  logic         sample;
  logic [N:0]   shift_register_out;
  logic [N-1:0] dac_code;
  logic [N-1:0] data_out;
  logic         data_valid;
  logic         busy;

  // Analog model: ideal comparator against an input code, or tied high/low.
  logic [N-1:0] vin;
  int           mode;   // 0 ideal, 1 tied high, 2 tied low

  int checks = 0;
  int errors = 0;

  assign comparator_out = (mode == 1) ? 1'b1 :
                          (mode == 2) ? 1'b0 : (vin >= dac_code);

  sar_sequencer #(.N_bits(N), .SAMPLE_CYCLES(SC)) dut (
    .clk                (clk),
    .rst                (rst),
    .start              (start),
    .comparator_out     (comparator_out),
    .data_ready         (data_ready),
    .sample             (sample),
    .shift_register_out (shift_register_out),
    .dac_code           (dac_code),
    .data_out           (data_out),
    .data_valid         (data_valid),
    .busy               (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Invariants sampled every cycle away from the active edge.
  always @(negedge clk) begin
    chk("onehot_or_zero", int'($countones(shift_register_out) <= 1), 1);
    chk("sample_vs_ptr", int'(sample), int'(shift_register_out[N]));
  end

  // Behavioural comparator decision used by the reference model.
  function automatic bit model_cmp(input int v, input int m, input int trial);
    if (m == 1) return 1'b1;
    if (m == 2) return 1'b0;
    return v >= trial;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_sample"}, int'(sample), 0);
    chk({tag, "_ptr"}, int'(shift_register_out), 0);
    chk({tag, "_dac"}, int'(dac_code), 0);
    chk({tag, "_valid"}, int'(data_valid), 0);
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  // One full conversion: start pulse, cycle-by-cycle phase checks against a
  // binary-search model, optional DONE stall with ignored start pulses, transfer.
  task automatic run_conv(input int v, input int m, input int hold, input bit poke, input int exp);
    int code;
    int trial;
    vin        = N'(v);
    mode       = m;
    start      = 1'b1;
    data_ready = 1'b0;
    step();
    start = 1'b0;
    for (int c = 0; c < SC; c++) begin
      if (c > 0) step();
      chk("samp_sample", int'(sample), 1);
      chk("samp_ptr", int'(shift_register_out), 1 << N);
      chk("samp_dac", int'(dac_code), 0);
      chk("samp_busy", int'(busy), 1);
      chk("samp_valid", int'(data_valid), 0);
    end
    code = 0;
    for (int k = N - 1; k >= 0; k--) begin
      step();
      trial = code | (1 << k);
      chk("conv_ptr", int'(shift_register_out), 1 << k);
      chk("conv_dac", int'(dac_code), trial);
      chk("conv_busy", int'(busy), 1);
      chk("conv_valid", int'(data_valid), 0);
      if (model_cmp(v, m, trial)) code = trial;
    end
    step();
    chk("done_valid", int'(data_valid), 1);
    chk("done_data", int'(data_out), exp);
    chk("done_model", int'(data_out), code);
    chk("done_dac", int'(dac_code), exp);
    chk("done_ptr", int'(shift_register_out), 0);
    chk("done_busy", int'(busy), 1);
    for (int h = 0; h < hold; h++) begin
      start = poke ? h[0] : 1'b0;
      step();
      chk("hold_valid", int'(data_valid), 1);
      chk("hold_data", int'(data_out), exp);
      chk("hold_busy", int'(busy), 1);
      chk("hold_ptr", int'(shift_register_out), 0);
    end
    start      = 1'b0;
    data_ready = 1'b1;
    step();
    data_ready = 1'b0;
    chk_idle("xfer");
    chk("xfer_data", int'(data_out), exp);
    step();
    chk("idle_noqueue_sample", int'(sample), 0);
    chk("idle_noqueue_busy", int'(busy), 0);
  endtask

  typedef struct {
    int vin;
    int mode;
    int hold;
    bit poke;
    int exp;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int v;
    int hold;
    vecs[0] = '{vin: 11, mode: 0, hold: 0, poke: 1'b0, exp: 4'b1011};
    vecs[1] = '{vin: 0,  mode: 1, hold: 0, poke: 1'b0, exp: 4'b1111};
    vecs[2] = '{vin: 15, mode: 2, hold: 0, poke: 1'b0, exp: 4'b0000};
    vecs[3] = '{vin: 9,  mode: 0, hold: 5, poke: 1'b1, exp: 4'b1001};
    vecs[4] = '{vin: 0,  mode: 0, hold: 1, poke: 1'b0, exp: 4'b0000};
    vecs[5] = '{vin: 15, mode: 0, hold: 2, poke: 1'b1, exp: 4'b1111};
    vecs[6] = '{vin: 8,  mode: 0, hold: 0, poke: 1'b0, exp: 4'b1000};

    rst        = 1'b0;
    start      = 1'b0;
    data_ready = 1'b0;
    vin        = '0;
    mode       = 0;
    #3;
    chk_idle("reset");
    chk("reset_data", int'(data_out), 0);
    @(negedge clk);
    rst = 1'b1;
    step();
    chk_idle("idle");

    for (int i = 0; i < 7; i++)
      run_conv(vecs[i].vin, vecs[i].mode, vecs[i].hold, vecs[i].poke, vecs[i].exp);

    // Reset during trial k=2 discards the partial result.
    vin   = 4'd13;
    mode  = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    chk("pre_rst_ptr", int'(shift_register_out), 1 << 2);
    #2 rst = 1'b0;
    #1;
    chk_idle("midrst");
    chk("midrst_data", int'(data_out), 0);
    @(negedge clk);
    rst = 1'b1;
    run_conv(6, 0, 0, 1'b0, 4'b0110);

    // Streaming with start and data_ready held high, alternating inputs.
    vin        = 4'd5;
    start      = 1'b1;
    data_ready = 1'b1;
    for (int c = 0; c < 28; c++) begin
      step();
      if ((c % 7) < SC) begin
        chk("strm_sample", int'(sample), 1);
        chk("strm_valid_low", int'(data_valid), 0);
      end else if ((c % 7) == 6) begin
        chk("strm_valid", int'(data_valid), 1);
        chk("strm_data", int'(data_out), ((c / 7) % 2 == 0) ? 5 : 10);
        vin = ((c / 7) % 2 == 0) ? 4'd10 : 4'd5;
        if (c == 27) start = 1'b0;
      end else begin
        chk("strm_sample_low", int'(sample), 0);
        chk("strm_busy", int'(busy), 1);
      end
    end
    step();
    data_ready = 1'b0;
    chk_idle("strm_end");

    // Random inputs with random DONE stalls; an ideal SAR returns the input code.
    for (int r = 0; r < 20; r++) begin
      v    = $urandom_range(0, 15);
      hold = $urandom_range(0, 3);
      run_conv(v, 0, hold, r[0], v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
